// File: rtl/pir_array_monitor.sv
// pir_array_monitor
//
// Multi-channel motion-detection monitor. Each accepted sample vector updates
// a per-channel moving average over a 2^AVG_LOG2-deep window. A channel trips
// the alarm after CONFIRM consecutive over-threshold averages. An
// OFF/ARMED/ALARM/SILENCED state machine handles operator acknowledge.
//
// Pipeline:
//   stage 1 (accepting edge)  window, running sum, avg_out, sample_count
//   stage 2 (following edge)  confirm counters, led, trip evaluation
//
// Ports:
//   clk, rst      rising-edge clock, synchronous active-high reset
//   turn          system enable; low forces OFF and clears the datapath
//   stop_alarm    operator acknowledge (ALARM -> SILENCED)
//   sample_valid  sensor_data carries a new sample vector
//   sensor_data   packed samples, channel i at [i*DATA_W +: DATA_W]
//   threshold     trip threshold, strict compare (avg > threshold)
//   avg_out       registered per-channel averages, same packing
//   led           per-channel over-threshold flags (stage 2)
//   buzzer        high only in ALARM
//   alarm_state   OFF=0, ARMED=1, ALARM=2, SILENCED=3
//   trip_channel  lowest channel that caused the last ALARM entry
//   event_count   ARMED->ALARM transitions, saturating
//   sample_count  accepted samples since rst, wrapping
module pir_array_monitor #(
  parameter int unsigned NUM_SENSORS = 3,
  parameter int unsigned DATA_W      = 7,
  parameter int unsigned AVG_LOG2    = 2,
  parameter int unsigned CONFIRM     = 2,
  parameter int unsigned CH_W        = (NUM_SENSORS > 1) ? $clog2(NUM_SENSORS) : 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          turn,
  input  logic                          stop_alarm,
  input  logic                          sample_valid,
  input  logic [NUM_SENSORS*DATA_W-1:0] sensor_data,
  input  logic [DATA_W-1:0]             threshold,
  output logic [NUM_SENSORS*DATA_W-1:0] avg_out,
  output logic [NUM_SENSORS-1:0]        led,
  output logic                          buzzer,
  output logic [1:0]                    alarm_state,
  output logic [CH_W-1:0]               trip_channel,
  output logic [15:0]                   event_count,
  output logic [15:0]                   sample_count
);

  localparam int unsigned Depth = 1 << AVG_LOG2;
  localparam int unsigned SumW  = DATA_W + AVG_LOG2;
  localparam int unsigned ConfW = $clog2(CONFIRM + 1);

  typedef enum logic [1:0] {
    StOff      = 2'd0,
    StArmed    = 2'd1,
    StAlarm    = 2'd2,
    StSilenced = 2'd3
  } state_e;

  state_e state_q;

  // Datapath state
  logic [DATA_W-1:0]             win_q  [NUM_SENSORS][Depth];
  logic [SumW-1:0]               sum_q  [NUM_SENSORS];
  logic [SumW-1:0]               sum_d  [NUM_SENSORS];
  logic [ConfW-1:0]              conf_q [NUM_SENSORS];
  logic [ConfW-1:0]              conf_d [NUM_SENSORS];
  logic [NUM_SENSORS*DATA_W-1:0] avg_q;
  logic [NUM_SENSORS*DATA_W-1:0] avg_d;
  logic [NUM_SENSORS-1:0]        led_q;
  logic [NUM_SENSORS-1:0]        over;
  logic                          s2_valid_q;

  // Control / status
  logic            accept;
  logic            clear;
  logic            any_confirmed;
  logic            all_quiet;
  logic [CH_W-1:0] first_ch;
  logic            buzzer_q;
  logic [CH_W-1:0] trip_q;
  logic [15:0]     event_q;
  logic [15:0]     sample_q;

  // Samples are never taken in the OFF-entry cycle, so a fresh ARMED period
  // always starts from empty windows.
  assign accept = sample_valid & turn & (state_q != StOff);
  assign clear  = ~turn | (state_q == StOff);

  // Stage 1 next-state: running sum keeps exactly the sum of the window, so it
  // never overflows SumW and the average fits DATA_W without saturation.
  always_comb begin
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      sum_d[i] = sum_q[i] + SumW'(sensor_data[i*DATA_W +: DATA_W])
                 - SumW'(win_q[i][Depth-1]);
      avg_d[i*DATA_W +: DATA_W] = sum_d[i][AVG_LOG2 +: DATA_W];
    end
  end

  // Stage 2 next-state: compare registered averages, update confirm counters
  // and pick the lowest-index channel that is (still) confirmed.
  always_comb begin
    logic found;
    found         = 1'b0;
    any_confirmed = 1'b0;
    first_ch      = '0;
    for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
      over[i]   = avg_q[i*DATA_W +: DATA_W] > threshold;
      conf_d[i] = conf_q[i];
      if (s2_valid_q) begin
        if (!over[i]) begin
          conf_d[i] = '0;
        end else if (conf_q[i] != ConfW'(CONFIRM)) begin
          conf_d[i] = conf_q[i] + ConfW'(1);
        end
      end
      if (conf_d[i] == ConfW'(CONFIRM)) begin
        any_confirmed = 1'b1;
        if (!found) begin
          found    = 1'b1;
          first_ch = CH_W'(i);
        end
      end
    end
    all_quiet = ~|over;
  end

  // Averaging datapath; OFF (or turn low) wipes every window and flag.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        for (int unsigned k = 0; k < Depth; k++) begin
          win_q[i][k] <= '0;
        end
        sum_q[i]  <= '0;
        conf_q[i] <= '0;
      end
      avg_q      <= '0;
      led_q      <= '0;
      s2_valid_q <= 1'b0;
    end else begin
      s2_valid_q <= accept;
      if (accept) begin
        for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
          for (int unsigned k = Depth - 1; k > 0; k--) begin
            win_q[i][k] <= win_q[i][k-1];
          end
          win_q[i][0] <= sensor_data[i*DATA_W +: DATA_W];
          sum_q[i]    <= sum_d[i];
        end
        avg_q <= avg_d;
      end
      if (s2_valid_q) begin
        led_q <= over;
      end
      for (int unsigned i = 0; i < NUM_SENSORS; i++) begin
        conf_q[i] <= conf_d[i];
      end
    end
  end

  // Sample counter survives OFF; only rst clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      sample_q <= '0;
    end else if (accept) begin
      sample_q <= sample_q + 16'd1;
    end
  end

  // Alarm state machine with registered buzzer, trip channel and event count.
  // turn low beats every other transition, including a same-cycle trip.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StOff;
      buzzer_q <= 1'b0;
      trip_q   <= '0;
      event_q  <= '0;
    end else if (!turn) begin
      state_q  <= StOff;
      buzzer_q <= 1'b0;
    end else begin
      unique case (state_q)
        StOff: begin
          state_q  <= StArmed;
          buzzer_q <= 1'b0;
        end
        StArmed: begin
          if (any_confirmed) begin
            state_q  <= StAlarm;
            buzzer_q <= 1'b1;
            trip_q   <= first_ch;
            if (event_q != 16'hFFFF) begin
              event_q <= event_q + 16'd1;
            end
          end
        end
        StAlarm: begin
          // A confirmation arriving with the acknowledge cannot re-trip here.
          if (stop_alarm) begin
            state_q  <= StSilenced;
            buzzer_q <= 1'b0;
          end
        end
        StSilenced: begin
          if (s2_valid_q && all_quiet) begin
            state_q <= StArmed;
          end
        end
        default: begin
          state_q  <= StOff;
          buzzer_q <= 1'b0;
        end
      endcase
    end
  end

  assign avg_out      = avg_q;
  assign led          = led_q;
  assign buzzer       = buzzer_q;
  assign alarm_state  = state_q;
  assign trip_channel = trip_q;
  assign event_count  = event_q;
  assign sample_count = sample_q;

endmodule

// File: tb/tb_pir_array_monitor.sv
// Bench for pir_array_monitor at default parameters, threshold 50.
// Control outputs are checked against a cycle table; averages are predicted
// by a window model and pushed to a scoreboard queue when stimulus is driven.
module tb_pir_array_monitor;

  localparam int NS = 3;
  localparam int DW = 7;

  logic            clk = 1'b0;
  logic            rst;
  logic            turn;
  logic            stop_alarm;
  logic            sample_valid;
  logic [NS*DW-1:0] sensor_data;
  logic [DW-1:0]   threshold;
  logic [NS*DW-1:0] avg_out;
  logic [NS-1:0]   led;
  logic            buzzer;
  logic [1:0]      alarm_state;
  logic [1:0]      trip_channel;
  logic [15:0]     event_count;
  logic [15:0]     sample_count;

  always #5 clk = ~clk;

  pir_array_monitor #(
    .NUM_SENSORS (3),
    .DATA_W      (7),
    .AVG_LOG2    (2),
    .CONFIRM     (2),
    .CH_W        (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .turn         (turn),
    .stop_alarm   (stop_alarm),
    .sample_valid (sample_valid),
    .sensor_data  (sensor_data),
    .threshold    (threshold),
    .avg_out      (avg_out),
    .led          (led),
    .buzzer       (buzzer),
    .alarm_state  (alarm_state),
    .trip_channel (trip_channel),
    .event_count  (event_count),
    .sample_count (sample_count)
  );

  typedef struct {
    bit rst;
    bit turn;
    bit stop;
    bit valid;
    int d0, d1, d2;
    int st, buz, led, trip, evt;
  } vec_t;

  vec_t             tbl[$];
  logic [NS*DW-1:0] sb[$];
  int               n_checks = 0;
  int               n_fail   = 0;

  task automatic chk(input string nm, input int row, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL row %0d %s: got %0h, want %0h", row, nm, act, exp);
    end
  endtask

  function automatic vec_t v(bit r, bit t, bit s, bit va, int a, int b, int c,
                             int st, int bz, int ld, int tr, int ev);
    vec_t x;
    x.rst = r; x.turn = t; x.stop = s; x.valid = va;
    x.d0 = a; x.d1 = b; x.d2 = c;
    x.st = st; x.buz = bz; x.led = ld; x.trip = tr; x.evt = ev;
    return x;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int              win[NS][4];
    int              prev_st;
    int              exp_scnt;
    logic [NS*DW-1:0] hold;
    logic [NS*DW-1:0] e;
    bit              clr;
    bit              acc;
    vec_t            t;

    threshold = 7'd50;

    // Reset with random inputs: every output must read zero.
    for (int k = 0; k < 3; k++) begin
      rst          = 1'b1;
      turn         = 1'($urandom);
      stop_alarm   = 1'($urandom);
      sample_valid = 1'($urandom);
      sensor_data  = 21'($urandom);
      @(posedge clk); #1;
      chk("reset avg_out", -1, 32'(avg_out), 0);
      chk("reset led", -1, 32'(led), 0);
      chk("reset buzzer", -1, 32'(buzzer), 0);
      chk("reset alarm_state", -1, 32'(alarm_state), 0);
      chk("reset trip_channel", -1, 32'(trip_channel), 0);
      chk("reset event_count", -1, 32'(event_count), 0);
      chk("reset sample_count", -1, 32'(sample_count), 0);
    end

    //             rst t  s  v  d0   d1   d2   st bz led    tr ev
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 1, 0, 3'b000, 0, 0)); // arm
    tbl.push_back(v(0, 1, 0, 1,   0, 100,   0, 1, 0, 3'b000, 0, 0)); // ramp ch1
    tbl.push_back(v(0, 1, 0, 1,   0, 100,   0, 1, 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 0, 1,   0, 100,   0, 1, 0, 3'b000, 0, 0));
    tbl.push_back(v(0, 1, 0, 1,   0, 100,   0, 1, 0, 3'b010, 0, 0));
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 2, 1, 3'b010, 1, 1)); // trip
    tbl.push_back(v(0, 1, 1, 0,   0,   0,   0, 3, 0, 3'b010, 1, 1)); // ack
    tbl.push_back(v(0, 1, 0, 1,   0,   0,   0, 3, 0, 3'b010, 1, 1)); // avg 75
    tbl.push_back(v(0, 1, 0, 1,   0,   0,   0, 3, 0, 3'b010, 1, 1)); // avg 50
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 1, 0, 3'b000, 1, 1)); // re-arm
    tbl.push_back(v(0, 1, 0, 1, 127,   0, 127, 1, 0, 3'b000, 1, 1)); // ch0+ch2
    tbl.push_back(v(0, 1, 0, 1, 127,   0, 127, 1, 0, 3'b000, 1, 1));
    tbl.push_back(v(0, 1, 0, 1, 127,   0, 127, 1, 0, 3'b101, 1, 1));
    tbl.push_back(v(0, 1, 0, 1, 127,   0, 127, 2, 1, 3'b101, 0, 2)); // lowest wins
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 2, 1, 3'b101, 0, 2));
    tbl.push_back(v(0, 0, 0, 0,   0,   0,   0, 0, 0, 3'b000, 0, 2)); // turn drop
    tbl.push_back(v(0, 0, 0, 1, 127, 127, 127, 0, 0, 3'b000, 0, 2)); // ignored
    tbl.push_back(v(0, 0, 0, 1, 127, 127, 127, 0, 0, 3'b000, 0, 2));
    tbl.push_back(v(0, 1, 0, 1, 127, 127, 127, 1, 0, 3'b000, 0, 2)); // entry cycle
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b000, 0, 2)); // ramp ch2
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b000, 0, 2));
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b100, 0, 2));
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 2, 1, 3'b100, 2, 3));
    tbl.push_back(v(0, 1, 1, 0,   0,   0,   0, 3, 0, 3'b100, 2, 3)); // ack+confirm
    tbl.push_back(v(0, 0, 0, 0,   0,   0,   0, 0, 0, 3'b000, 2, 3));
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 1, 0, 3'b000, 2, 3));
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b000, 2, 3));
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b000, 2, 3));
    tbl.push_back(v(0, 1, 0, 1,   0,   0, 127, 1, 0, 3'b100, 2, 3));
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 2, 1, 3'b100, 2, 4));
    tbl.push_back(v(1, 1, 0, 1, 127, 127, 127, 0, 0, 3'b000, 0, 0)); // rst in ALARM
    tbl.push_back(v(0, 1, 0, 0,   0,   0,   0, 1, 0, 3'b000, 0, 0));

    prev_st  = 0;
    exp_scnt = 0;
    hold     = '0;
    for (int c = 0; c < NS; c++)
      for (int k = 0; k < 4; k++) win[c][k] = 0;

    for (int r = 0; r < tbl.size(); r++) begin
      t            = tbl[r];
      rst          = t.rst;
      turn         = t.turn;
      stop_alarm   = t.stop;
      sample_valid = t.valid;
      sensor_data  = {7'(t.d2), 7'(t.d1), 7'(t.d0)};

      clr = t.rst || !t.turn || (prev_st == 0);
      acc = !clr && t.valid;
      if (clr) begin
        for (int c = 0; c < NS; c++)
          for (int k = 0; k < 4; k++) win[c][k] = 0;
        hold = '0;
      end else if (acc) begin
        e = '0;
        for (int c = 0; c < NS; c++) begin
          for (int k = 3; k > 0; k--) win[c][k] = win[c][k-1];
          win[c][0] = (c == 0) ? t.d0 : (c == 1) ? t.d1 : t.d2;
          e[c*DW +: DW] = 7'((win[c][0] + win[c][1] + win[c][2] + win[c][3]) >> 2);
        end
        sb.push_back(e);
      end
      if (t.rst) exp_scnt = 0;
      else if (acc) exp_scnt++;

      @(posedge clk); #1;

      if (acc) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL row %0d scoreboard: got empty queue, want an entry", r);
        end else begin
          hold = sb.pop_front();
        end
      end
      chk("avg_out", r, 32'(avg_out), 32'(hold));
      chk("alarm_state", r, 32'(alarm_state), 32'(t.st));
      chk("buzzer", r, 32'(buzzer), 32'(t.buz));
      chk("led", r, 32'(led), 32'(t.led));
      chk("trip_channel", r, 32'(trip_channel), 32'(t.trip));
      chk("event_count", r, 32'(event_count), 32'(t.evt));
      chk("sample_count", r, 32'(sample_count), 32'(exp_scnt));
      prev_st = t.st;
    end

    chk("scoreboard drained", -1, 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pir_array_monitor.md
# pir_array_monitor

Parametrised multi-channel motion-detection monitor, next generation of the three-sensor PIR alarm block. It accepts NUM_SENSORS packed sensor samples per valid strobe and keeps a per-channel moving average over a 2^AVG_LOG2-sample window. It raises an alarm only after CONFIRM consecutive over-threshold averages, and it runs an armed/alarm/silenced state machine with operator acknowledge. It sits between the sensor front-end and the LED/buzzer/display logic of the motion-detection design.

## Interface
Parameters:
- NUM_SENSORS, 3, number of sensor channels (≥1)
- DATA_W, 7, sample width per channel (unsigned)
- AVG_LOG2, 2, log2 of averaging window depth (window = 4 samples)
- CONFIRM, 2, consecutive over-threshold averages required to trip (≥1)
- CH_W, max(1, clog2(NUM_SENSORS)), width of trip_channel

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- turn  in  1  system enable; low forces OFF
- stop_alarm  in  1  operator acknowledge, level-sampled each cycle
- sample_valid  in  1  sensor_data valid this cycle
- sensor_data  in  NUM_SENSORS*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- threshold  in  DATA_W  trip threshold, compared strictly (avg > threshold)
- avg_out  out  NUM_SENSORS*DATA_W  registered per-channel averages, same packing
- led  out  NUM_SENSORS  per-channel over-threshold indicator
- buzzer  out  1  high only in ALARM
- alarm_state  out  2  OFF=0, ARMED=1, ALARM=2, SILENCED=3
- trip_channel  out  CH_W  channel that caused the last ALARM entry
- event_count  out  16  number of ARMED→ALARM transitions, saturating at 0xFFFF
- sample_count  out  16  accepted samples since rst, wraps modulo 2^16

## Operation
- A sample is accepted when sample_valid & turn & state≠OFF-entry cycle; sample_valid is ignored while turn=0.
- Per channel: a shift window of 2^AVG_LOG2 entries and a running sum of width DATA_W+AVG_LOG2. On accept: sum ← sum + new − oldest; shift. The average is sum >> AVG_LOG2, so it is always ≤ 2^DATA_W−1 and no saturation is needed. The window starts at zero, so the average ramps up.
- Per-channel confirm counter (0..CONFIRM, saturating): on each stage-2 valid, avg > threshold → increment; otherwise → 0. led[i] = avg_i > threshold, updated at stage 2, and forced 0 in OFF.
- FSM:
  - OFF: all windows, sums, confirm counters, avg_out and led are cleared. Go to ARMED when turn=1.
  - ARMED: if any confirm counter reaches CONFIRM, go to ALARM. On that entry, trip_channel ← lowest-index confirmed channel and event_count += 1 (saturating).
  - ALARM: buzzer=1. stop_alarm=1 → SILENCED.
  - SILENCED: buzzer=0, led remains live. When a stage-2 valid has every channel avg ≤ threshold → ARMED.
  - Any state with turn=0 → OFF. This has priority over all other transitions.
- Counters and averaging keep running in ALARM and SILENCED. A channel's confirm count staying at CONFIRM does not re-trip until the FSM passes through ARMED.
- Simultaneous events:
  - stop_alarm in the same cycle as a trip condition while in ALARM → SILENCED.
  - An ARMED trip and turn=0 in the same cycle → OFF, with no event_count increment.
  - Multiple channels confirming on the same stage-2 cycle → the lowest index wins.
- event_count, sample_count and trip_channel are cleared only by rst, not by OFF.

## Timing
- Reset (rst=1 at an edge): state=OFF. avg_out, led, buzzer, trip_channel, event_count, sample_count, windows, sums and counters are all 0. rst overrides every other input. After rst drops, the first edge with turn=1 moves the FSM to ARMED.
- Stage 1 (edge E, accepting edge): window, sum, avg_out and sample_count update. avg_out reflects the sample accepted at E from E+1 onward.
- Stage 2 (edge E+1): confirm counters and led update from avg_out; the FSM evaluates the trip. buzzer rises at E+1 when the sample accepted at E completes confirmation.
- stop_alarm high before edge T in ALARM → buzzer low after T (1-cycle response).
- turn low before edge T → state=OFF and buzzer/led/avg_out = 0 after T.
- Back-to-back samples on every cycle are supported at full throughput.

## Test plan
(Default parameters, threshold=50.)
- **Reset:** Hold rst 3 cycles with random inputs → every output 0, alarm_state=0. Then turn=1 → alarm_state=1 after one edge.
- **Trip by ramp:** Four consecutive samples of channel 1 = 100, others 0 → avg_out[1] = 25, 50, 75, 100. Confirm count is 1 after sample 3. At the stage-2 edge of sample 4: alarm_state=2, buzzer=1, trip_channel=1, event_count=1, led=3'b010.
- **Acknowledge and re-arm:** Pulse stop_alarm in ALARM → state 3, buzzer 0 next edge, led[1]=1. Feed two samples of 0 → avg 75 then 50. State goes to 1 at stage 2 of the second zero.
- **Simultaneous trip:** Channels 0 and 2 fed 127 for four samples → avg 127, trip_channel=0, event_count increments by exactly 1.
- **Enable drop mid-alarm:** turn=0 while in ALARM → next edge state 0, buzzer 0, avg_out 0, led 0. event_count unchanged. sample_valid pulses while turn=0 leave sample_count unchanged.
- **Reset mid-alarm / ack collision:** stop_alarm and a new confirmation on the same edge in ALARM → state 3 with no increment. rst asserted in ALARM → all outputs 0 at the next edge, including event_count.
